// File: rtl/segre_pkg.sv
// Shared types and constants for the Segre RV32I core.
// The memory stage adds its FSM encoding, the byte-enable width and an alignment helper.
package segre_pkg;

  localparam int ADDR_SIZE = 32;
  localparam int WORD_SIZE = 32;
  localparam int REG_SIZE  = 5;
  localparam int BE_W      = 4;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } memop_data_type_e;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_REQ,
    MEM_RESP
  } mem_fsm_state_e;

  // True when the low address bits do not fit the natural alignment of the access size.
  function automatic logic is_misaligned(input memop_data_type_e data_type, input logic [1:0] offset);
    case (data_type)
      HALF:    return offset[0];
      WORD:    return offset != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/segre_mem_align.sv
// Byte-lane steering for the memory stage: store byte enables / replicated write data,
// and load byte/halfword extraction with sign or zero extension.
module segre_mem_align
  import segre_pkg::*;
(
  input  memop_data_type_e       data_type,
  input  logic [1:0]             offset,
  input  logic                   sign_ext,
  input  logic [WORD_SIZE-1:0]   wdata,
  input  logic [WORD_SIZE-1:0]   rdata,
  output logic [BE_W-1:0]        be,
  output logic [WORD_SIZE-1:0]   wdata_lane,
  output logic [WORD_SIZE-1:0]   rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = rdata[{offset, 3'b000} +: 8];
    half_sel   = offset[1] ? rdata[31:16] : rdata[15:0];
    be         = 4'hF;
    wdata_lane = wdata;
    rdata_ext  = rdata;
    // Unaligned low bits are dropped here; HALF only looks at offset[1].
    case (data_type)
      BYTE: begin
        be         = 4'b0001 << offset;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      end
      HALF: begin
        be         = 4'b0011 << {offset[1], 1'b0};
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{sign_ext & half_sel[15]}}, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/segre_mem_stage.sv
// Memory stage of the Segre RV32I core: EX -> data memory (req/gnt/rvalid) -> WB.
// Define SEGRE_MISALIGN_CHECK_EN to trap misaligned accesses instead of truncating the address.
module segre_mem_stage
  import segre_pkg::*;
#(
  parameter int ADDR_W = ADDR_SIZE,
  parameter int DATA_W = WORD_SIZE,
  parameter int REG_W  = REG_SIZE
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic              ex_mem_rd_i,
  input  logic              ex_mem_wr_i,
  input  logic [ADDR_W-1:0] ex_alu_res_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic [1:0]        ex_data_type_i,
  input  logic              ex_sign_ext_i,
  input  logic              ex_rf_we_i,
  input  logic [REG_W-1:0]  ex_rd_i,
  output logic              dmem_req_o,
  input  logic              dmem_gnt_i,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [BE_W-1:0]   dmem_be_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_rvalid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              wb_valid_o,
  output logic              wb_rf_we_o,
  output logic [REG_W-1:0]  wb_rd_o,
  output logic [DATA_W-1:0] wb_data_o
`ifdef SEGRE_MISALIGN_CHECK_EN
  ,
  output logic              misaligned_o,
  output logic [ADDR_W-1:0] misaligned_addr_o
`endif
);

  mem_fsm_state_e   state;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  memop_data_type_e lat_type;
  logic              lat_sign_ext;
  logic              lat_rf_we;
  logic [REG_W-1:0]  lat_rd;
  logic              lat_store;

  logic              mem_op;
  logic              misaligned;
  logic [BE_W-1:0]   be;
  logic [DATA_W-1:0] wdata_lane;
  logic [DATA_W-1:0] rdata_ext;

  assign mem_op = ex_mem_rd_i | ex_mem_wr_i;
`ifdef SEGRE_MISALIGN_CHECK_EN
  assign misaligned = is_misaligned(memop_data_type_e'(ex_data_type_i), ex_alu_res_i[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  segre_mem_align u_align (
    .data_type  (lat_type),
    .offset     (lat_addr[1:0]),
    .sign_ext   (lat_sign_ext),
    .wdata      (lat_wdata),
    .rdata      (dmem_rdata_i),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext)
  );

  assign ex_ready_o   = (state == MEM_IDLE);
  assign dmem_req_o   = (state == MEM_REQ);
  assign dmem_we_o    = dmem_req_o & lat_store;
  assign dmem_addr_o  = {lat_addr[ADDR_W-1:2], 2'b00};
  assign dmem_be_o    = dmem_req_o ? be : '0;
  assign dmem_wdata_o = wdata_lane;

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state             <= MEM_IDLE;
      lat_addr          <= '0;
      lat_wdata         <= '0;
      lat_type          <= BYTE;
      lat_sign_ext      <= 1'b0;
      lat_rf_we         <= 1'b0;
      lat_rd            <= '0;
      lat_store         <= 1'b0;
      wb_valid_o        <= 1'b0;
      wb_rf_we_o        <= 1'b0;
      wb_rd_o           <= '0;
      wb_data_o         <= '0;
`ifdef SEGRE_MISALIGN_CHECK_EN
      misaligned_o      <= 1'b0;
      misaligned_addr_o <= '0;
`endif
    end else begin
      wb_valid_o <= 1'b0;
`ifdef SEGRE_MISALIGN_CHECK_EN
      misaligned_o <= 1'b0;
`endif
      case (state)
        MEM_IDLE: begin
          if (ex_valid_i) begin
            lat_addr     <= ex_alu_res_i;
            lat_wdata    <= ex_wdata_i;
            lat_type     <= memop_data_type_e'(ex_data_type_i);
            lat_sign_ext <= ex_sign_ext_i;
            lat_rf_we    <= ex_rf_we_i;
            lat_rd       <= ex_rd_i;
            // A simultaneous load+store request is resolved as a store.
            lat_store    <= ex_mem_wr_i;
            if (mem_op && misaligned) begin
              wb_valid_o <= 1'b1;
              wb_rf_we_o <= 1'b0;
              wb_rd_o    <= ex_rd_i;
`ifdef SEGRE_MISALIGN_CHECK_EN
              misaligned_o      <= 1'b1;
              misaligned_addr_o <= ex_alu_res_i;
`endif
            end else if (mem_op) begin
              state <= MEM_REQ;
            end else begin
              wb_valid_o <= 1'b1;
              wb_rf_we_o <= ex_rf_we_i;
              wb_rd_o    <= ex_rd_i;
              wb_data_o  <= ex_alu_res_i;
            end
          end
        end
        MEM_REQ: begin
          if (dmem_gnt_i) begin
            if (lat_store) begin
              wb_valid_o <= 1'b1;
              wb_rf_we_o <= 1'b0;
              wb_rd_o    <= lat_rd;
              state      <= MEM_IDLE;
            end else begin
              state <= MEM_RESP;
            end
          end
        end
        MEM_RESP: begin
          if (dmem_rvalid_i) begin
            wb_valid_o <= 1'b1;
            wb_rf_we_o <= lat_rf_we;
            wb_rd_o    <= lat_rd;
            wb_data_o  <= rdata_ext;
            state      <= MEM_IDLE;
          end
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end

endmodule

// File: doc/segre_mem_stage.md
Name: segre_mem_stage

Overview:
- Memory stage of the Segre RV32I core. Sits between EX (ALU result, store data) and WB (register-file write).
- Performs loads and stores over a req/gnt/rvalid data-memory port, including byte-lane alignment and load sign/zero extension.
- Passes non-memory results through to WB in one cycle.
- Backpressures EX with a ready signal while a memory access is outstanding.

Parameters:
- ADDR_W, segre_pkg::ADDR_SIZE (32), address width.
- DATA_W, segre_pkg::WORD_SIZE (32), data width. Only 32 is supported.
- REG_W, segre_pkg::REG_SIZE (5), register index width.

Ports:
- clk_i  in  1  clock
- rsn_i  in  1  asynchronous active-low reset
- ex_valid_i  in  1  EX presents an instruction
- ex_ready_o  out  1  stage can accept
- ex_mem_rd_i  in  1  instruction is a load
- ex_mem_wr_i  in  1  instruction is a store
- ex_alu_res_i  in  ADDR_W  effective address, or the pass-through result
- ex_wdata_i  in  DATA_W  store data
- ex_data_type_i  in  2  memop_data_type_e: BYTE/HALF/WORD
- ex_sign_ext_i  in  1  1 = sign-extend load (LB/LH), 0 = zero-extend (LBU/LHU)
- ex_rf_we_i  in  1  instruction writes rd
- ex_rd_i  in  REG_W  destination register
- dmem_req_o  out  1  request
- dmem_gnt_i  in  1  request accepted
- dmem_we_o  out  1  write
- dmem_addr_o  out  ADDR_W  word-aligned address, bits [1:0] = 0
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  DATA_W  lane-replicated store data
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  DATA_W  read data
- wb_valid_o  out  1  one-cycle result pulse to WB
- wb_rf_we_o  out  1  register write enable
- wb_rd_o  out  REG_W  destination register
- wb_data_o  out  DATA_W  result

Behaviour:
- Reset:
  - State returns to IDLE.
  - All outputs are 0 except ex_ready_o, which is 1.
  - Reset asserted mid-access drops dmem_req_o immediately. Any later rvalid is ignored.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - ex_ready_o=1.
  - When ex_valid_i is high, latch all ex_* inputs.
  - Non-memory instruction: next cycle wb_valid_o=1, wb_data_o=ex_alu_res_i, wb_rf_we_o=ex_rf_we_i. State stays IDLE, so back-to-back issue gives one instruction per cycle.
  - Load or store: go to REQ.
  - ex_mem_rd_i and ex_mem_wr_i both high is illegal. It is treated as a store.
- REQ:
  - ex_ready_o=0. dmem_req_o=1, held with stable address/be/wdata until dmem_gnt_i.
  - On gnt, a store completes: next cycle wb_valid_o=1 with wb_rf_we_o=0, state IDLE.
  - On gnt, a load goes to RESP.
- RESP:
  - ex_ready_o=0, dmem_req_o=0. Wait for dmem_rvalid_i.
  - When rvalid arrives, next cycle wb_valid_o=1 with the extended data, state IDLE.
  - rvalid in the same cycle as gnt is not allowed; the memory returns it at least one cycle later.
- Latency with gnt and rvalid each immediate:
  - store: 2 cycles from accept to wb_valid_o.
  - load: 3 cycles from accept to wb_valid_o.
  - pass-through: 1 cycle.
- wb_valid_o is a single-cycle pulse. wb_* hold their values until the next pulse.
- Byte enables and store data, with o = addr[1:0]:
  - BYTE: be = 1<<o; wdata = {4{wdata[7:0]}}.
  - HALF: be = 4'b0011<<(2*addr[1]); wdata = {2{wdata[15:0]}}.
  - WORD: be = 4'hF; wdata unchanged.
- Load data:
  - BYTE: select rdata byte o.
  - HALF: select halfword addr[1].
  - WORD: rdata unchanged.
  - Extend to 32 bits per the latched sign_ext flag.
- Misaligned accesses (HALF with addr[0]=1, WORD with addr[1:0]≠0) behave as listed under Optional Feature.

Optional Feature:
- Macro: SEGRE_MISALIGN_CHECK_EN.
- Defined:
  - A misaligned access issues no dmem request.
  - Next cycle: wb_valid_o=1, wb_rf_we_o=0.
  - Extra output ports are present: misaligned_o (1-cycle pulse, same cycle) and misaligned_addr_o (ADDR_W, holds the offending address until the next misalignment, reset 0).
- Undefined:
  - Low address bits that do not fit the access size are ignored: HALF uses addr[1] only, WORD uses neither bit.
  - The access proceeds normally and the extra ports are absent.

Decomposition:
- segre_pkg adds:
  - mem_fsm_state_e {MEM_IDLE, MEM_REQ, MEM_RESP}.
  - Constant BE_W = 4.
  - memop_data_type_e is reused, not redefined.
- One combinational sub-module, segre_mem_align: store byte-enable/wdata generation and load extract/extend.
- The top level holds the FSM and the registers.

Test Plan:
- Pass-through: three back-to-back ALU results 0x11, 0x22, 0x33 to rd 1..3 → three consecutive wb pulses with matching data; ex_ready_o stays 1.
- SB of 0xA5 at 0x1003, gnt delayed 3 cycles → dmem_req_o held 4 cycles; be=4'b1000, wdata=0xA5A5A5A5, addr=0x1000; wb pulse with rf_we=0.
- LB at 0x2001, rdata=0x0000_8000, sign_ext=1 → wb_data=0xFFFF_FF80. LBU of the same address → 0x0000_0080.
- LH at 0x2002, rdata=0x8001_0000 → wb_data=0xFFFF_8001. LW at 0x2000 with rvalid 5 cycles after gnt → ex_ready_o low throughout; data exact.
- rsn_i asserted while in RESP, then released, then a stale rvalid arrives → no wb pulse, state IDLE, ex_ready_o=1.
- With SEGRE_MISALIGN_CHECK_EN: LW at 0x3002 → no dmem_req_o; misaligned_o pulse; misaligned_addr_o=0x3002.
- Without SEGRE_MISALIGN_CHECK_EN: LW at 0x3002 → addr 0x3000, be=4'hF.
